// File: rtl/kugelblitz_offload_pipe.sv
// Multi-channel AXI-stream byte-transform stage with AXI-lite control and per-channel counters.
// Each channel has a registered output stage backed by a one-entry skid buffer.
module kugelblitz_offload_pipe #(
  parameter int unsigned DATA_WIDTH      = 512,
  parameter int unsigned KEEP_WIDTH      = DATA_WIDTH / 8,
  parameter int unsigned USER_WIDTH      = 1,
  parameter int unsigned CH_COUNT        = 2,
  parameter int unsigned AXIL_ADDR_WIDTH = 8,
  parameter int unsigned AXIL_DATA_WIDTH = 32
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [CH_COUNT*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [CH_COUNT*KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic [CH_COUNT-1:0]            s_axis_tvalid,
  output logic [CH_COUNT-1:0]            s_axis_tready,
  input  logic [CH_COUNT-1:0]            s_axis_tlast,
  input  logic [CH_COUNT*USER_WIDTH-1:0] s_axis_tuser,
  output logic [CH_COUNT*DATA_WIDTH-1:0] m_axis_tdata,
  output logic [CH_COUNT*KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic [CH_COUNT-1:0]            m_axis_tvalid,
  input  logic [CH_COUNT-1:0]            m_axis_tready,
  output logic [CH_COUNT-1:0]            m_axis_tlast,
  output logic [CH_COUNT*USER_WIDTH-1:0] m_axis_tuser,
  input  logic [AXIL_ADDR_WIDTH-1:0]     s_axil_awaddr,
  input  logic                           s_axil_awvalid,
  output logic                           s_axil_awready,
  input  logic [AXIL_DATA_WIDTH-1:0]     s_axil_wdata,
  input  logic [AXIL_DATA_WIDTH/8-1:0]   s_axil_wstrb,
  input  logic                           s_axil_wvalid,
  output logic                           s_axil_wready,
  output logic [1:0]                     s_axil_bresp,
  output logic                           s_axil_bvalid,
  input  logic                           s_axil_bready,
  input  logic [AXIL_ADDR_WIDTH-1:0]     s_axil_araddr,
  input  logic                           s_axil_arvalid,
  output logic                           s_axil_arready,
  output logic [AXIL_DATA_WIDTH-1:0]     s_axil_rdata,
  output logic [1:0]                     s_axil_rresp,
  output logic                           s_axil_rvalid,
  input  logic                           s_axil_rready
);

  localparam logic [0:0] StIdle    = 1'b0;
  localparam logic [0:0] StInFrame = 1'b1;
  localparam int unsigned ChIdxW   = AXIL_ADDR_WIDTH - 4;

  logic                       awready_q, bvalid_q, arready_q, rvalid_q;
  logic [31:0]                rdata_q, rd_val;
  logic                       wr_en, rd_en;
  logic [ChIdxW-1:0]          wr_ch, rd_ch;
  logic [3:0]                 wr_off, rd_off;
  logic [31:0]                ctrl_all   [CH_COUNT];
  logic [31:0]                frames_all [CH_COUNT];
  logic [31:0]                drops_all  [CH_COUNT];
  logic [2:0]                 status_all [CH_COUNT];

  assign wr_en  = awready_q & s_axil_awvalid & s_axil_wvalid;
  assign rd_en  = arready_q & s_axil_arvalid;
  assign wr_ch  = s_axil_awaddr[AXIL_ADDR_WIDTH-1:4];
  assign wr_off = s_axil_awaddr[3:0];
  assign rd_ch  = s_axil_araddr[AXIL_ADDR_WIDTH-1:4];
  assign rd_off = s_axil_araddr[3:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      awready_q <= 1'b0;
      bvalid_q  <= 1'b0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      awready_q <= s_axil_awvalid & s_axil_wvalid & ~bvalid_q & ~awready_q;
      if (wr_en)              bvalid_q <= 1'b1;
      else if (s_axil_bready) bvalid_q <= 1'b0;
      arready_q <= s_axil_arvalid & ~rvalid_q & ~arready_q;
      if (rd_en) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_val;
      end else if (s_axil_rready) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  // Unmapped channels and offsets fall through to zero.
  always_comb begin
    rd_val = '0;
    for (int c = 0; c < CH_COUNT; c++) begin
      if (rd_ch == ChIdxW'(c)) begin
        case (rd_off)
          4'h0:    rd_val = ctrl_all[c];
          4'h4:    rd_val = frames_all[c];
          4'h8:    rd_val = drops_all[c];
          4'hC:    rd_val = {29'd0, status_all[c]};
          default: rd_val = '0;
        endcase
      end
    end
  end

  assign s_axil_awready = awready_q;
  assign s_axil_wready  = awready_q;
  assign s_axil_bvalid  = bvalid_q;
  assign s_axil_bresp   = 2'b00;
  assign s_axil_arready = arready_q;
  assign s_axil_rvalid  = rvalid_q;
  assign s_axil_rdata   = rdata_q;
  assign s_axil_rresp   = 2'b00;

  for (genvar c = 0; c < CH_COUNT; c++) begin : g_ch
    logic [DATA_WIDTH-1:0] in_data, xdata, out_data_q, skid_data_q;
    logic [KEEP_WIDTH-1:0] in_keep, out_keep_q, skid_keep_q;
    logic [USER_WIDTH-1:0] in_user, out_user_q, skid_user_q;
    logic                  in_last, out_last_q, skid_last_q;
    logic                  out_valid_q, skid_valid_q, s_ready_q;
    logic                  in_fire, prod, out_free, skid_next, m_ready;
    logic                  wsel, ctrl_wr, frames_clr, drops_clr;
    logic [0:0]            state_q;
    logic [31:0]           ctrl_q, frames_q, drops_q;
    logic [1:0]            act_mode_q, cur_mode;
    logic [7:0]            act_add_q, cur_add;

    assign in_data  = s_axis_tdata[c*DATA_WIDTH +: DATA_WIDTH];
    assign in_keep  = s_axis_tkeep[c*KEEP_WIDTH +: KEEP_WIDTH];
    assign in_user  = s_axis_tuser[c*USER_WIDTH +: USER_WIDTH];
    assign in_last  = s_axis_tlast[c];
    assign m_ready  = m_axis_tready[c];

    assign wsel       = wr_en && (wr_ch == ChIdxW'(c));
    assign ctrl_wr    = wsel && (wr_off == 4'h0);
    assign frames_clr = wsel && (wr_off == 4'h4);
    assign drops_clr  = wsel && (wr_off == 4'h8);

    // Mid-frame the latched settings apply; on a first beat CTRL is used directly.
    assign cur_mode  = (state_q == StInFrame) ? act_mode_q : ctrl_q[1:0];
    assign cur_add   = (state_q == StInFrame) ? act_add_q : ctrl_q[15:8];
    assign in_fire   = s_axis_tvalid[c] & s_ready_q;
    assign prod      = in_fire & (cur_mode != 2'd3);
    assign out_free  = ~out_valid_q | m_ready;
    assign skid_next = out_free ? 1'b0 : (skid_valid_q | prod);

    always_comb begin
      xdata = in_data;
      for (int k = 0; k < KEEP_WIDTH; k++) begin
        case (cur_mode)
          2'd1:    xdata[8*k +: 8] = in_keep[k] ? in_data[8*k +: 8] : 8'h00;
          2'd2:    xdata[8*k +: 8] = in_keep[k] ? in_data[8*k +: 8] + 8'(k) + cur_add : 8'h00;
          default: xdata[8*k +: 8] = in_data[8*k +: 8];
        endcase
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        out_valid_q  <= 1'b0;
        out_data_q   <= '0;
        out_keep_q   <= '0;
        out_last_q   <= 1'b0;
        out_user_q   <= '0;
        skid_valid_q <= 1'b0;
        skid_data_q  <= '0;
        skid_keep_q  <= '0;
        skid_last_q  <= 1'b0;
        skid_user_q  <= '0;
        s_ready_q    <= 1'b0;
      end else begin
        s_ready_q <= ~skid_next;
        if (out_free) begin
          if (skid_valid_q) begin
            out_valid_q  <= 1'b1;
            out_data_q   <= skid_data_q;
            out_keep_q   <= skid_keep_q;
            out_last_q   <= skid_last_q;
            out_user_q   <= skid_user_q;
            skid_valid_q <= 1'b0;
          end else begin
            out_valid_q <= prod;
            if (prod) begin
              out_data_q <= xdata;
              out_keep_q <= in_keep;
              out_last_q <= in_last;
              out_user_q <= in_user;
            end
          end
        end else if (prod) begin
          skid_valid_q <= 1'b1;
          skid_data_q  <= xdata;
          skid_keep_q  <= in_keep;
          skid_last_q  <= in_last;
          skid_user_q  <= in_user;
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q    <= StIdle;
        act_mode_q <= 2'd0;
        act_add_q  <= 8'd0;
        ctrl_q     <= '0;
        frames_q   <= '0;
        drops_q    <= '0;
      end else begin
        if (in_fire) begin
          state_q <= in_last ? StIdle : StInFrame;
          if (state_q == StIdle) begin
            act_mode_q <= ctrl_q[1:0];
            act_add_q  <= ctrl_q[15:8];
          end
        end
        if (ctrl_wr) begin
          for (int b = 0; b < 4; b++) begin
            if (s_axil_wstrb[b]) ctrl_q[8*b +: 8] <= s_axil_wdata[8*b +: 8];
          end
        end
        if (frames_clr)                             frames_q <= '0;
        else if (out_valid_q & m_ready & out_last_q) frames_q <= frames_q + 32'd1;
        if (drops_clr)                                         drops_q <= '0;
        else if (in_fire & in_last & (cur_mode == 2'd3))       drops_q <= drops_q + 32'd1;
      end
    end

    assign ctrl_all[c]   = ctrl_q;
    assign frames_all[c] = frames_q;
    assign drops_all[c]  = drops_q;
    assign status_all[c] = {act_mode_q, state_q == StInFrame};

    assign s_axis_tready[c]                            = s_ready_q;
    assign m_axis_tvalid[c]                            = out_valid_q;
    assign m_axis_tdata[c*DATA_WIDTH +: DATA_WIDTH]    = out_data_q;
    assign m_axis_tkeep[c*KEEP_WIDTH +: KEEP_WIDTH]    = out_keep_q;
    assign m_axis_tlast[c]                             = out_last_q;
    assign m_axis_tuser[c*USER_WIDTH +: USER_WIDTH]    = out_user_q;
  end

endmodule

// File: tb/tb_kugelblitz_offload_pipe.sv
// Directed bench for kugelblitz_offload_pipe: expected beats are queued per channel at issue
// time and popped by per-channel monitors whenever an output beat transfers.
module tb_kugelblitz_offload_pipe;

  localparam int DW = 512;
  localparam int KW = 64;
  localparam int UW = 1;
  localparam int CH = 2;
  localparam int AW = 8;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
    logic [UW-1:0] user;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0] s_data_a  [CH];
  logic [KW-1:0] s_keep_a  [CH];
  logic          s_valid_a [CH];
  logic          s_last_a  [CH];
  logic [UW-1:0] s_user_a  [CH];
  logic          m_ready_a [CH];

  logic [CH*DW-1:0] s_axis_tdata, m_axis_tdata;
  logic [CH*KW-1:0] s_axis_tkeep, m_axis_tkeep;
  logic [CH-1:0]    s_axis_tvalid, s_axis_tready, s_axis_tlast;
  logic [CH-1:0]    m_axis_tvalid, m_axis_tready, m_axis_tlast;
  logic [CH*UW-1:0] s_axis_tuser, m_axis_tuser;

  logic [AW-1:0] awaddr, araddr;
  logic          awvalid, awready, wvalid, wready, bvalid, bready;
  logic          arvalid, arready, rvalid, rready;
  logic [31:0]   wdata, rdata;
  logic [3:0]    wstrb;
  logic [1:0]    bresp, rresp;

  for (genvar c = 0; c < CH; c++) begin : g_pack
    assign s_axis_tdata[c*DW +: DW] = s_data_a[c];
    assign s_axis_tkeep[c*KW +: KW] = s_keep_a[c];
    assign s_axis_tvalid[c]         = s_valid_a[c];
    assign s_axis_tlast[c]          = s_last_a[c];
    assign s_axis_tuser[c*UW +: UW] = s_user_a[c];
    assign m_axis_tready[c]         = m_ready_a[c];
  end

  kugelblitz_offload_pipe #(
    .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_WIDTH(UW), .CH_COUNT(CH),
    .AXIL_ADDR_WIDTH(AW), .AXIL_DATA_WIDTH(32)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
    .s_axil_awaddr(awaddr), .s_axil_awvalid(awvalid), .s_axil_awready(awready),
    .s_axil_wdata(wdata), .s_axil_wstrb(wstrb), .s_axil_wvalid(wvalid), .s_axil_wready(wready),
    .s_axil_bresp(bresp), .s_axil_bvalid(bvalid), .s_axil_bready(bready),
    .s_axil_araddr(araddr), .s_axil_arvalid(arvalid), .s_axil_arready(arready),
    .s_axil_rdata(rdata), .s_axil_rresp(rresp), .s_axil_rvalid(rvalid), .s_axil_rready(rready)
  );

  int    n_cmp = 0;
  int    n_bad = 0;
  beat_t exp_q [CH][$];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: no handshake within cycle budget, required one", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitors: one per channel.
  for (genvar c = 0; c < CH; c++) begin : g_mon
    beat_t e;
    always @(negedge clk) begin
      if (rst_n && m_axis_tvalid[c] && m_ready_a[c]) begin
        if (exp_q[c].size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL ch%0d_unexpected_beat: got data %0h, required no output", c,
                   m_axis_tdata[c*DW +: DW]);
        end else begin
          e = exp_q[c].pop_front();
          chk($sformatf("ch%0d_data", c), m_axis_tdata[c*DW +: DW], e.data);
          chk($sformatf("ch%0d_keep", c), DW'(m_axis_tkeep[c*KW +: KW]), DW'(e.keep));
          chk($sformatf("ch%0d_last", c), DW'(m_axis_tlast[c]), DW'(e.last));
          chk($sformatf("ch%0d_user", c), DW'(m_axis_tuser[c*UW +: UW]), DW'(e.user));
        end
      end
    end
  end

  // ch0 occupancy: never more than two beats held, and tready low whenever both are full.
  int acc0 = 0;
  int out0 = 0;
  bit occ_en = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      acc0 = 0;
      out0 = 0;
    end else begin
      if (occ_en) begin
        chk("ch0_occupancy_le_2", DW'(acc0 - out0 <= 2), DW'(1));
        if (acc0 - out0 == 2) chk("ch0_tready_when_full", DW'(s_axis_tready[0]), DW'(0));
      end
      if (s_valid_a[0] && s_axis_tready[0]) acc0++;
      if (m_axis_tvalid[0] && m_ready_a[0]) out0++;
    end
  end

  task automatic send(input int c, input logic [DW-1:0] d, input logic [KW-1:0] k,
                      input logic l, input logic [UW-1:0] u, input bit exp_en,
                      input logic [DW-1:0] ed);
    int n;
    bit ok;
    if (exp_en) exp_q[c].push_back('{data: ed, keep: k, last: l, user: u});
    s_data_a[c] = d;
    s_keep_a[c] = k;
    s_last_a[c] = l;
    s_user_a[c] = u;
    s_valid_a[c] = 1'b1;
    n = 0;
    ok = 1'b0;
    while (!ok && n < 200) begin
      @(negedge clk);
      ok = s_axis_tready[c];
      tick();
      n++;
    end
    s_valid_a[c] = 1'b0;
    if (!ok) timeout($sformatf("ch%0d_send", c));
  endtask

  task automatic axil_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s);
    int n;
    bit ok;
    awaddr = a;
    wdata = d;
    wstrb = s;
    awvalid = 1'b1;
    wvalid = 1'b1;
    n = 0;
    ok = 1'b0;
    while (!ok && n < 50) begin
      @(negedge clk);
      ok = awready && wready;
      tick();
      n++;
    end
    awvalid = 1'b0;
    wvalid = 1'b0;
    if (!ok) timeout("axil_aw");
    n = 0;
    ok = 1'b0;
    while (!ok && n < 50) begin
      @(negedge clk);
      ok = bvalid;
      if (ok) chk("axil_bresp", DW'(bresp), DW'(0));
      tick();
      n++;
    end
    if (!ok) timeout("axil_b");
  endtask

  task automatic chk_reg(input string name, input logic [AW-1:0] a, input logic [31:0] exp);
    int n;
    bit ok;
    logic [31:0] got;
    araddr = a;
    arvalid = 1'b1;
    n = 0;
    ok = 1'b0;
    while (!ok && n < 50) begin
      @(negedge clk);
      ok = arready;
      tick();
      n++;
    end
    arvalid = 1'b0;
    if (!ok) timeout("axil_ar");
    n = 0;
    ok = 1'b0;
    got = '0;
    while (!ok && n < 50) begin
      @(negedge clk);
      ok = rvalid;
      if (ok) begin
        got = rdata;
        chk("axil_rresp", DW'(rresp), DW'(0));
      end
      tick();
      n++;
    end
    if (!ok) timeout("axil_r");
    else chk(name, DW'(got), DW'(exp));
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q[0].size() != 0 || exp_q[1].size() != 0) && n < 500) begin
      tick();
      n++;
    end
    if (n >= 500) timeout("drain");
    tick();
  endtask

  function automatic logic [DW-1:0] pat(input logic [31:0] x);
    return {16{x}};
  endfunction

  function automatic logic [DW-1:0] ramp();
    logic [DW-1:0] r;
    for (int k = 0; k < KW; k++) r[8*k +: 8] = 8'(k);
    return r;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required $finish");
    $fatal(1);
  end

  logic [DW-1:0] d, e;

  initial begin
    for (int c = 0; c < CH; c++) begin
      s_data_a[c] = '0;
      s_keep_a[c] = '0;
      s_valid_a[c] = 1'b0;
      s_last_a[c] = 1'b0;
      s_user_a[c] = '0;
      m_ready_a[c] = 1'b1;
    end
    awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    bready = 1'b1; rready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_m_tvalid", DW'(m_axis_tvalid), DW'(0));
    chk("rst_s_tready", DW'(s_axis_tready), DW'(0));
    chk("rst_m_tdata", m_axis_tdata[DW-1:0], '0);
    chk("rst_m_keep_last_user", DW'({m_axis_tkeep, m_axis_tlast, m_axis_tuser}), DW'(0));
    chk("rst_axil_handshakes", DW'({awready, wready, bvalid, arready, rvalid}), DW'(0));
    chk("rst_axil_data", DW'({rdata, rresp, bresp}), DW'(0));
    rst_n = 1'b1;
    tick();
    chk("s_tready_after_reset", DW'(s_axis_tready), DW'(2'b11));
    chk_reg("ch0_ctrl_reset", 8'h00, 32'h0);
    chk_reg("ch1_status_reset", 8'h1C, 32'h0);

    // Pass-through, one 64-byte frame, 1-cycle latency
    d = ramp();
    send(0, d, '1, 1'b1, 1'b0, 1'b1, d);
    @(negedge clk);
    chk("ch0_latency_1", DW'(m_axis_tvalid[0]), DW'(1));
    drain();
    chk_reg("ch0_frames_1", 8'h04, 32'd1);

    // Masked byte-add on ch1: 0xFF + k + 0x10
    axil_write(8'h10, 32'h0000_1002, 4'hF);
    e = '0;
    e[31:0] = 32'h1211_100F;
    send(1, '1, 64'hF, 1'b1, 1'b1, 1'b1, e);
    drain();
    chk_reg("ch1_frames_1", 8'h14, 32'd1);
    axil_write(8'h10, 32'hFFFF_FF03, 4'b0001);
    chk_reg("ch1_ctrl_wstrb", 8'h10, 32'h0000_1003);

    // Mask mode with output backpressure 1,0,0,1,...
    axil_write(8'h00, 32'h1, 4'hF);
    occ_en = 1'b1;
    fork
      begin
        d = pat(32'hA5A5_0000);
        e = '0;
        e[255:0] = d[255:0];
        send(0, d, 64'h0000_0000_FFFF_FFFF, 1'b0, 1'b0, 1'b1, e);
        d = pat(32'hA5A5_0001);
        e = '0;
        e[511:256] = d[511:256];
        send(0, d, 64'hFFFF_FFFF_0000_0000, 1'b0, 1'b0, 1'b1, e);
        d = pat(32'hA5A5_0002);
        send(0, d, '1, 1'b0, 1'b0, 1'b1, d);
        d = pat(32'hA5A5_0003);
        e = '0;
        e[7:0] = 8'h03;
        send(0, d, 64'h1, 1'b1, 1'b0, 1'b1, e);
      end
      begin
        for (int i = 0; i < 24; i++) begin
          m_ready_a[0] = (i % 4 == 0) || (i % 4 == 3);
          tick();
        end
        m_ready_a[0] = 1'b1;
      end
    join
    drain();
    occ_en = 1'b0;

    // Drop mode on ch1 with its output stalled; ch0 keeps flowing
    m_ready_a[1] = 1'b0;
    fork
      begin
        for (int f = 0; f < 3; f++) begin
          send(1, pat(32'hDEAD_0000), '1, 1'b0, 1'b0, 1'b0, '0);
          send(1, pat(32'hDEAD_0001), '1, 1'b1, 1'b0, 1'b0, '0);
        end
      end
      begin
        for (int f = 0; f < 2; f++) begin
          d = pat(32'hC0DE_0000 + 32'(f));
          send(0, d, '1, 1'b1, 1'b0, 1'b1, d);
        end
      end
    join
    drain();
    m_ready_a[1] = 1'b1;
    chk_reg("ch1_drops_3", 8'h18, 32'd3);
    axil_write(8'h18, 32'h0, 4'hF);
    chk_reg("ch1_drops_cleared", 8'h18, 32'd0);
    chk_reg("ch1_frames_unchanged", 8'h14, 32'd1);
    chk_reg("ch0_frames_4", 8'h04, 32'd4);

    // CTRL change mid-frame only takes effect at the next frame
    axil_write(8'h00, 32'h0, 4'hF);
    chk_reg("ch0_status_idle_mode1", 8'h0C, 32'h2);
    d = pat(32'h5000_0000);
    send(0, d, '1, 1'b0, 1'b0, 1'b1, d);
    d = pat(32'h5000_0001);
    send(0, d, 64'h0000_0000_FFFF_FFFF, 1'b0, 1'b0, 1'b1, d);
    axil_write(8'h00, 32'h1, 4'hF);
    chk_reg("ch0_status_inframe_mode0", 8'h0C, 32'h1);
    d = pat(32'h5000_0002);
    send(0, d, 64'hFF, 1'b1, 1'b0, 1'b1, d);
    drain();
    chk_reg("ch0_status_idle_mode0", 8'h0C, 32'h0);
    d = pat(32'h5000_0003);
    e = '0;
    e[63:0] = d[63:0];
    send(0, d, 64'hFF, 1'b1, 1'b0, 1'b1, e);
    drain();
    chk_reg("ch0_status_idle_mode1_next", 8'h0C, 32'h2);
    chk_reg("ch0_frames_6", 8'h04, 32'd6);

    // Unmapped address: write ignored, reads zero
    axil_write(8'h20, 32'hFFFF_FFFF, 4'hF);
    chk_reg("unmapped_read_zero", 8'h20, 32'h0);
    chk_reg("ch0_ctrl_untouched", 8'h00, 32'h1);

    // Asynchronous reset mid-frame
    m_ready_a[0] = 1'b0;
    send(0, ramp(), '1, 1'b0, 1'b0, 1'b0, '0);
    @(negedge clk);
    chk("ch0_pending_before_reset", DW'(m_axis_tvalid[0]), DW'(1));
    tick();
    rst_n = 1'b0;
    #1;
    chk("async_reset_m_tvalid", DW'(m_axis_tvalid), DW'(0));
    chk("async_reset_s_tready", DW'(s_axis_tready), DW'(0));
    m_ready_a[0] = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk_reg("ch0_status_after_reset", 8'h0C, 32'h0);
    d = ramp();
    send(0, d, '1, 1'b1, 1'b0, 1'b1, d);
    drain();
    chk_reg("ch0_frames_after_reset", 8'h04, 32'd1);

    chk("ch0_queue_empty", DW'(exp_q[0].size()), DW'(0));
    chk("ch1_queue_empty", DW'(exp_q[1].size()), DW'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
